// File: rtl/ldpc_3gpp_enc_read_ctrl.sv
// ldpc_3gpp_enc_read_ctrl
//   Sequences one codeword of reads out of the encoder input ping-pong buffer:
//   waits for a full buffer, clears the address generator, issues reads under
//   a credit scheme, tags sop/eop/valid in step with the RAM latency, and
//   releases the buffer once the last word has been issued.
//   Optional build macro: LDPC_3GPP_ENC_READ_CTRL_ABORT_EN adds the iabort input.
module ldpc_3gpp_enc_read_ctrl #(
  parameter int pLEN_W    = 8,
  parameter int pCREDIT_W = 3,
  parameter int pCREDITS  = 4,
  parameter int pRAM_LAT  = 2
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iclkena,
  input  logic [pLEN_W-1:0] iused_len,
  input  logic              ibuf_full,
  input  logic              icredit,
`ifdef LDPC_3GPP_ENC_READ_CTRL_ABORT_EN
  input  logic              iabort,
`endif
  output logic              oclear,
  output logic              oenable,
  output logic              obuf_empty,
  output logic              oval,
  output logic              osop,
  output logic              oeop,
  output logic              obusy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DRAIN_W = (pRAM_LAT > 1) ? $clog2(pRAM_LAT) : 1;
  localparam logic [DRAIN_W-1:0]   DRAIN_LAST  = DRAIN_W'(pRAM_LAT - 1);
  localparam logic [pCREDIT_W-1:0] CREDIT_MAX  = {pCREDIT_W{1'b1}};
  localparam logic [pCREDIT_W-1:0] CREDIT_INIT = pCREDIT_W'(pCREDITS);

  state_t               state_q, state_d;
  logic [pLEN_W-1:0]    len_q, len_d;
  logic [pLEN_W-1:0]    cnt_q, cnt_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic [pCREDIT_W-1:0] credit_q, credit_d;
  logic                 empty_q, empty_d;
  logic [pRAM_LAT-1:0]  val_q, val_d;
  logic [pRAM_LAT-1:0]  sop_q, sop_d;
  logic [pRAM_LAT-1:0]  eop_q, eop_d;

  logic abort;
  logic abort_hit;
  logic rd_en;
  logic sop_in;
  logic eop_in;

`ifdef LDPC_3GPP_ENC_READ_CTRL_ABORT_EN
  assign abort = iabort;
`else
  assign abort = 1'b0;
`endif

  // Abort only matters while a block is in progress
  assign abort_hit = abort && (state_q != IDLE);

  // A read is issued only in READ with a credit in hand; abort kills it the same tick
  assign rd_en  = (state_q == READ) && (credit_q != '0) && !abort;
  assign sop_in = rd_en && (cnt_q == '0);
  assign eop_in = rd_en && (cnt_q == len_q);

  // Tag shift register: stage 0 takes the word being issued, the last stage drives the outputs
  generate
    for (genvar gi = 0; gi < pRAM_LAT; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        assign val_d[gi] = !abort_hit && rd_en;
        assign sop_d[gi] = !abort_hit && sop_in;
        assign eop_d[gi] = !abort_hit && eop_in;
      end else begin : g_body
        assign val_d[gi] = !abort_hit && val_q[gi-1];
        assign sop_d[gi] = !abort_hit && sop_q[gi-1];
        assign eop_d[gi] = !abort_hit && eop_q[gi-1];
      end
    end
  endgenerate

  // Next-state, counters and credit bookkeeping
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    drain_d  = drain_q;
    credit_d = credit_q;
    empty_d  = 1'b0;

    // A credit returned in the same tick as a read cancels out
    if (rd_en && !icredit) begin
      credit_d = credit_q - 1'b1;
    end else if (!rd_en && icredit && (credit_q != CREDIT_MAX)) begin
      credit_d = credit_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (ibuf_full) begin
          len_d   = iused_len;
          cnt_d   = '0;
          state_d = READ;
        end
      end
      READ: begin
        if (rd_en) begin
          cnt_d = cnt_q + 1'b1;
          // Last word issued: release the buffer now, tags still flushing
          if (cnt_q == len_q) begin
            state_d = DRAIN;
            empty_d = 1'b1;
            drain_d = '0;
          end
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = IDLE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort_hit) begin
      state_d = IDLE;
      empty_d = 1'b1;
    end
  end

  // State register; everything holds while the clock enable is low
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      state_q  <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      drain_q  <= '0;
      credit_q <= CREDIT_INIT;
      empty_q  <= 1'b0;
      val_q    <= '0;
      sop_q    <= '0;
      eop_q    <= '0;
    end else if (iclkena) begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      drain_q  <= drain_d;
      credit_q <= credit_d;
      empty_q  <= empty_d;
      val_q    <= val_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
    end
  end

  // The clear tick is the start tick itself; kept low while reset is asserted
  assign oclear     = ireset && (state_q == IDLE) && ibuf_full;
  assign oenable    = rd_en;
  assign obuf_empty = empty_q;
  assign oval       = val_q[pRAM_LAT-1];
  assign osop       = sop_q[pRAM_LAT-1];
  assign oeop       = eop_q[pRAM_LAT-1];
  assign obusy      = (state_q != IDLE);

endmodule

// File: tb/tb_ldpc_3gpp_enc_read_ctrl.sv
// Directed bench for ldpc_3gpp_enc_read_ctrl with an sop/eop scoreboard.
// Inputs change 1 ns after the rising edge; the monitor samples on the falling edge.
module tb_ldpc_3gpp_enc_read_ctrl;

  logic       iclk = 1'b0;
  logic       ireset = 1'b0;
  logic       iclkena = 1'b1;
  logic [7:0] iused_len = 8'd0;
  logic       ibuf_full = 1'b0;
  logic       icredit;
  logic       icr_man = 1'b0;
  logic       loop_en = 1'b0;
  logic       oval_d1 = 1'b0;
`ifdef LDPC_3GPP_ENC_READ_CTRL_ABORT_EN
  logic       iabort = 1'b0;
`endif
  logic oclear, oenable, obuf_empty, oval, osop, oeop, obusy;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0, clr_cnt = 0, emp_cnt = 0, val_cnt = 0, eop_cnt = 0;
  int en0, clr0, emp0, val0, eop0;
  logic [1:0] exp_q[$];
  logic [6:0] exp_v;

  ldpc_3gpp_enc_read_ctrl #(
    .pLEN_W(8), .pCREDIT_W(3), .pCREDITS(4), .pRAM_LAT(2)
  ) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .iused_len(iused_len),
    .ibuf_full(ibuf_full), .icredit(icredit),
`ifdef LDPC_3GPP_ENC_READ_CTRL_ABORT_EN
    .iabort(iabort),
`endif
    .oclear(oclear), .oenable(oenable), .obuf_empty(obuf_empty), .oval(oval),
    .osop(osop), .oeop(oeop), .obusy(obusy)
  );

  always #5 iclk = ~iclk;

  // Downstream model: optionally returns one credit the tick after each oval
  assign icredit = loop_en ? oval_d1 : icr_man;
  always @(posedge iclk) if (iclkena) oval_d1 <= oval;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic push_block(input int len);
    for (int i = 0; i <= len; i++) exp_q.push_back({i == 0, i == len});
  endtask

  // Pulses ibuf_full for the start tick; returns one tick later (t1)
  task automatic start_block(input int len);
    push_block(len);
    iused_len = 8'(len);
    ibuf_full = 1'b1;
    tick();
    ibuf_full = 1'b0;
  endtask

  task automatic snap();
    en0 = en_cnt; clr0 = clr_cnt; emp0 = emp_cnt; val0 = val_cnt; eop0 = eop_cnt;
  endtask

  function automatic logic [6:0] outv();
    return {oclear, oenable, oval, osop, oeop, obuf_empty, obusy};
  endfunction

  // Monitor: event counters and scoreboard pop on every valid word
  always @(negedge iclk) begin
    if (ireset && iclkena) begin
      if (oenable) en_cnt++;
      if (oclear) clr_cnt++;
      if (obuf_empty) emp_cnt++;
      if (oval) begin
        logic [1:0] e;
        val_cnt++;
        if (oeop) eop_cnt++;
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_sop", 32'(osop), 32'(e[1]));
          chk("sb_eop", 32'(oeop), 32'(e[0]));
        end
      end
    end
  end

  initial begin
    // Reset state, with ibuf_full high to show oclear stays low in reset
    ibuf_full = 1'b1;
    ticks(3);
    #1 chk("reset_outputs", 32'(outv()), 32'd0);
    ibuf_full = 1'b0;
    ireset = 1'b1;
    ticks(2);

    // Basic block: len 7, credits looped back
    loop_en = 1'b1;
    push_block(7);
    iused_len = 8'd7;
    ibuf_full = 1'b1;
    for (int t = 0; t <= 12; t++) begin
      #1;
      exp_v = {t == 0, (t >= 1) && (t <= 8), (t >= 3) && (t <= 10), t == 3, t == 10,
               t == 9, (t >= 1) && (t <= 10)};
      chk($sformatf("basic_t%0d", t), 32'(outv()), 32'(exp_v));
      tick();
      if (t == 0) ibuf_full = 1'b0;
    end
    chk("basic_sb_drained", 32'(exp_q.size()), 32'd0);
    $display("txn basic: len=7 enables=%0d words=%0d", en_cnt, val_cnt);

    // Backpressure: no credits returned
    loop_en = 1'b0;
    snap();
    start_block(9);
    ticks(12);
    chk("bp_first_enables", 32'(en_cnt - en0), 32'd4);
    chk("bp_stalled", 32'(oenable), 32'd0);
    for (int i = 0; i < 3; i++) begin
      icr_man = 1'b1; tick(); icr_man = 1'b0; ticks(3);
    end
    ticks(3);
    chk("bp_after_3_credits", 32'(en_cnt - en0), 32'd7);
    chk("bp_still_busy", 32'(obusy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      icr_man = 1'b1; tick(); icr_man = 1'b0; ticks(3);
    end
    ticks(4);
    chk("bp_total_enables", 32'(en_cnt - en0), 32'd10);
    chk("bp_done", 32'(obusy), 32'd0);
    chk("bp_one_release", 32'(emp_cnt - emp0), 32'd1);
    chk("bp_one_eop", 32'(eop_cnt - eop0), 32'd1);
    chk("bp_sb_drained", 32'(exp_q.size()), 32'd0);
    $display("txn backpressure: len=9 enables=%0d", en_cnt - en0);

    // Single-word block: credits are 0, return exactly one
    icr_man = 1'b1; tick(); icr_man = 1'b0;
    loop_en = 1'b1;
    snap();
    start_block(0);
    ticks(8);
    chk("single_enables", 32'(en_cnt - en0), 32'd1);
    chk("single_words", 32'(val_cnt - val0), 32'd1);
    chk("single_eop", 32'(eop_cnt - eop0), 32'd1);
    chk("single_release", 32'(emp_cnt - emp0), 32'd1);
    chk("single_clear", 32'(clr_cnt - clr0), 32'd1);
    loop_en = 1'b0;
    $display("txn single: len=0 words=%0d", val_cnt - val0);

    // Credit and enable in the same tick with one credit in hand
    snap();
    start_block(5);
    icr_man = 1'b1;
    for (int t = 1; t <= 6; t++) begin
      #1 chk($sformatf("simul_en_t%0d", t), 32'(oenable), 32'd1);
      tick();
    end
    icr_man = 1'b0;
    ticks(5);
    chk("simul_enables", 32'(en_cnt - en0), 32'd6);
    $display("txn simultaneous: len=5 enables=%0d", en_cnt - en0);

    // Credits left at exactly 1, then clock-enable freeze mid-READ
    snap();
    start_block(15);
    ticks(6);
    chk("credit_left_one", 32'(en_cnt - en0), 32'd1);
    icr_man = 1'b1;
    ticks(6);
    iclkena = 1'b0;
    en0 = en_cnt;
    for (int t = 0; t < 5; t++) begin
      #1 chk($sformatf("freeze_t%0d", t), 32'(outv()), 32'(7'b0110001));
      tick();
    end
    chk("freeze_no_enables", 32'(en_cnt - en0), 32'd0);
    iclkena = 1'b1;
    ticks(2);

    // Asynchronous reset mid-block
    ireset = 1'b0;
    icr_man = 1'b0;
    #1 chk("midreset_outputs", 32'(outv()), 32'd0);
    exp_q.delete();
    ticks(2);
    ireset = 1'b1;
    tick();
    chk("midreset_no_release", 32'(emp_cnt - emp0), 32'd0);
    $display("txn reset: mid-block reset applied");

    // Credits reloaded by reset
    snap();
    start_block(9);
    ticks(12);
    chk("reload_enables", 32'(en_cnt - en0), 32'd4);
    chk("reload_words", 32'(val_cnt - val0), 32'd4);
    ireset = 1'b0;
    tick();
    exp_q.delete();
    ireset = 1'b1;
    tick();
    $display("txn reload: enables=%0d", en_cnt - en0);

`ifdef LDPC_3GPP_ENC_READ_CTRL_ABORT_EN
    // Abort on the third enable
    snap();
    start_block(7);
    ticks(2);
    iabort = 1'b1;
    #1 chk("abort_en_same_tick", 32'(oenable), 32'd0);
    tick();
    iabort = 1'b0;
    #1 chk("abort_release", 32'(obuf_empty), 32'd1);
    chk("abort_idle", 32'(obusy), 32'd0);
    ticks(6);
    chk("abort_enables", 32'(en_cnt - en0), 32'd2);
    chk("abort_words", 32'(val_cnt - val0), 32'd1);
    chk("abort_no_eop", 32'(eop_cnt - eop0), 32'd0);
    chk("abort_one_release", 32'(emp_cnt - emp0), 32'd1);
    exp_q.delete();
    iabort = 1'b1;
    ticks(3);
    iabort = 1'b0;
    chk("abort_idle_ignored", 32'(emp_cnt - emp0), 32'd1);
    $display("txn abort: enables=%0d", en_cnt - en0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
